// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// reg_bank_pkg : shared constants and PC source select type for reg_bank_mp
// Revision     : 1.0
// ============================================================================
package reg_bank_pkg;

   localparam int c_pc_idx_def = 15;
   localparam int c_lr_idx_def = 14;
   localparam int c_pc_inc     = 4;

   typedef enum logic [1:0] {
      PSEL_WA   = 2'd0,
      PSEL_WB   = 2'd1,
      PSEL_HOLD = 2'd2,
      PSEL_NEXT = 2'd3
   } preg_sel_e;

endpackage
`default_nettype wire

// File: rtl/reg_bank_pc_ctrl.sv
`default_nettype none
// ============================================================================
// reg_bank_pc_ctrl : PC source priority, wrap check, link address, flush pulse
// Revision         : 1.0
// ============================================================================
module reg_bank_pc_ctrl
   import reg_bank_pkg::*;
#(
   parameter int          DATA_W      = 32,
   parameter int unsigned PC_WRAP_MAX = 60
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wa_pc_hit,
   input  logic [DATA_W-1:0] wa_data,
   input  logic              wb_pc_hit,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [DATA_W-1:0] pc_next,
   input  logic              stall,
   input  logic              bl,
   output logic [DATA_W-1:0] pc_out,
   output logic              pc_wr_evt,
   output logic              lr_cap,
   output logic [DATA_W-1:0] lr_data
);

   preg_sel_e         w_sel;
   logic [DATA_W-1:0] w_pc_sel;
   logic [DATA_W-1:0] w_pc_new;
   logic [DATA_W-1:0] r_pc;
   logic              r_wr_evt;

   // Write-port loads outrank stall so a taken branch is never lost.
   always_comb begin
      w_sel = PSEL_NEXT;
      if (wa_pc_hit)      w_sel = PSEL_WA;
      else if (wb_pc_hit) w_sel = PSEL_WB;
      else if (stall)     w_sel = PSEL_HOLD;
   end

   always_comb begin
      case (w_sel)
         PSEL_WA:   w_pc_sel = wa_data;
         PSEL_WB:   w_pc_sel = wb_data;
         PSEL_HOLD: w_pc_sel = r_pc;
         default:   w_pc_sel = pc_next;
      endcase
      w_pc_new = (w_pc_sel > DATA_W'(PC_WRAP_MAX)) ? '0 : w_pc_sel;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= '0;
         r_wr_evt <= 1'b0;
      end else begin
         r_pc     <= w_pc_new;
         r_wr_evt <= (w_sel == PSEL_WA) || (w_sel == PSEL_WB);
      end
   end

   assign pc_out    = r_pc;
   assign pc_wr_evt = r_wr_evt;
   assign lr_cap    = bl & ~stall;
   assign lr_data   = r_pc + DATA_W'(c_pc_inc);

endmodule
`default_nettype wire

// File: rtl/reg_bank_mp.sv
`default_nettype none
// ============================================================================
// reg_bank_mp : multi-port register bank with PC/LR handling and write bypass
// Revision    : 1.0
// ============================================================================
module reg_bank_mp
   import reg_bank_pkg::*;
#(
   parameter int          DATA_W      = 32,
   parameter int          NUM_REGS    = 16,
   parameter int          NUM_RD      = 4,
   parameter int          PC_IDX      = c_pc_idx_def,
   parameter int          LR_IDX      = c_lr_idx_def,
   parameter int unsigned PC_WRAP_MAX = 60,
   parameter bit          BYPASS      = 1'b1,
   localparam int         AW          = $clog2(NUM_REGS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*AW-1:0]     raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   input  logic                     wa_en,
   input  logic [AW-1:0]            wa_addr,
   input  logic [DATA_W-1:0]        wa_data,
   input  logic                     wb_en,
   input  logic [AW-1:0]            wb_addr,
   input  logic [DATA_W-1:0]        wb_data,
   input  logic [DATA_W-1:0]        pc_next,
   input  logic                     stall,
   input  logic                     bl,
   output logic [DATA_W-1:0]        pc_out,
   output logic                     pc_wr_evt
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [DATA_W-1:0] w_pc;
   logic              w_lr_cap;
   logic [DATA_W-1:0] w_lr_data;
   logic              w_wa_pc_hit;
   logic              w_wb_pc_hit;

   assign w_wa_pc_hit = wa_en && (wa_addr == AW'(PC_IDX));
   assign w_wb_pc_hit = wb_en && (wb_addr == AW'(PC_IDX));

   reg_bank_pc_ctrl #(
      .DATA_W      (DATA_W),
      .PC_WRAP_MAX (PC_WRAP_MAX)
   ) u_pc_ctrl (
      .clk       (clk),
      .rst       (rst),
      .wa_pc_hit (w_wa_pc_hit),
      .wa_data   (wa_data),
      .wb_pc_hit (w_wb_pc_hit),
      .wb_data   (wb_data),
      .pc_next   (pc_next),
      .stall     (stall),
      .bl        (bl),
      .pc_out    (w_pc),
      .pc_wr_evt (pc_wr_evt),
      .lr_cap    (w_lr_cap),
      .lr_data   (w_lr_data)
   );

   // The PC slot of the array is never written; the PC lives in u_pc_ctrl.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (i == LR_IDX && w_lr_cap) begin
               r_regs[i] <= w_lr_data;
            end else if (i != PC_IDX) begin
               if (wa_en && wa_addr == AW'(i))      r_regs[i] <= wa_data;
               else if (wb_en && wb_addr == AW'(i)) r_regs[i] <= wb_data;
            end
         end
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0]     w_ra;
      logic [DATA_W-1:0] w_rd;

      assign w_ra = raddr[p*AW +: AW];

      always_comb begin
         if (w_ra == AW'(PC_IDX))                       w_rd = w_pc;
         else if (BYPASS && wa_en && wa_addr == w_ra)   w_rd = wa_data;
         else if (BYPASS && wb_en && wb_addr == w_ra)   w_rd = wb_data;
         else                                           w_rd = r_regs[w_ra];
      end

      assign rdata[p*DATA_W +: DATA_W] = w_rd;
   end

   assign pc_out = w_pc;

endmodule
`default_nettype wire

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
Parametrised successor to the core's 16-entry register file. It provides NUM_RD combinational read ports and two synchronous write ports: port A for ALU/branch results and port B for load writeback. The PC register updates every cycle with stall, wrap and BL link capture. An optional write-to-read bypass is included. It sits between decode (read addresses), the execute/writeback stages (write ports) and the fetch unit (PC).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 16, register count (power of two, >=16); AW = $clog2(NUM_REGS)
NUM_RD, 4, number of read ports
PC_IDX, 15, index of the program counter register
LR_IDX, 14, index of the link register
PC_WRAP_MAX, 60, largest legal PC; any new PC value above this is replaced by 0
BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read ports return stored value only

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
raddr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
rdata  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
wa_en  in  1  write port A enable
wa_addr  in  AW  write port A address
wa_data  in  DATA_W  write port A data
wb_en  in  1  write port B enable
wb_addr  in  AW  write port B address
wb_data  in  DATA_W  write port B data
pc_next  in  DATA_W  sequential next PC from fetch
stall  in  1  freeze PC and link capture this cycle
bl  in  1  branch-with-link: capture return address into LR
pc_out  out  DATA_W  current PC register value (registered)
pc_wr_evt  out  1  registered pulse: PC was loaded from a write port last cycle (fetch flush)

Behaviour:
- Reset: while rst=1, all registers clear to 0 asynchronously, including PC and LR. pc_out=0, pc_wr_evt=0. rdata reflects the cleared array. Reset mid-cycle discards any pending write.
- Read ports: combinational. rdata[i] = reg[raddr[i]]. With BYPASS=1, the read returns wa_data if wa_en and wa_addr==raddr[i]. Otherwise it returns wb_data if wb_en and wb_addr==raddr[i]. Otherwise it returns the stored value. No bypass is applied for PC_IDX reads; those return the stored PC.
- General writes (address != PC_IDX, != LR_IDX while bl active) take effect at the rising edge.
- Same-address collision of A and B: port A wins, and B is dropped for that cycle.
- PC update each edge, in priority order:
  1) wa_en and wa_addr==PC_IDX -> wa_data, pc_wr_evt=1
  2) wb_en and wb_addr==PC_IDX -> wb_data, pc_wr_evt=1
  3) stall=1 -> hold, pc_wr_evt=0
  4) else -> pc_next, pc_wr_evt=0
- Write-port PC loads override stall.
- PC wrap: after selection, if the new value > PC_WRAP_MAX (unsigned), store 0. Applies to every source.
- Link capture: if bl=1 and stall=0, LR <= current PC + 4, i.e. the pre-update PC value, modulo 2^DATA_W. This overrides any A/B write to LR_IDX in the same cycle. bl with stall=1 is ignored, and decode must hold bl asserted.
- pc_wr_evt is a single-cycle registered pulse, cleared by reset.
- Width rules: all arithmetic is unsigned DATA_W. The +4 carry-out is discarded.

Decomposition:
- Package reg_bank_pkg: PC_IDX/LR_IDX default constants, the PC increment constant (4), and typedef preg_sel_e (PSEL_WA, PSEL_WB, PSEL_HOLD, PSEL_NEXT) for the PC source mux.
- One sub-module, reg_bank_pc_ctrl: PC priority mux, wrap check, LR return-address adder and pc_wr_evt flop.
- The array and read/bypass muxing stay in reg_bank_mp.

Test Plan:
- Reset: write r3=0xDEADBEEF, then assert rst asynchronously mid-cycle -> all rdata=0, pc_out=0 immediately. Release; next edge with pc_next=4 -> pc_out=4.
- Dual write and collision: wa r2=0x11, wb r5=0x22 in one cycle -> r2=0x11, r5=0x22. Next cycle wa r7=0xAA and wb r7=0xBB -> r7=0xAA.
- Bypass: BYPASS=1, raddr0=6, wb r6=0x1234 same cycle -> rdata0=0x1234 before the edge. With BYPASS=0 -> old value until after the edge.
- PC priority and wrap: pc=8, stall=1, wb to PC=20 -> pc=20, pc_wr_evt=1 next cycle. Then pc_next=64 -> pc=0. pc_next=60 -> pc=60.
- BL: pc=24, bl=1, pc_next=40, wa r14=0x99 same cycle -> LR=28, pc=40. Repeat with stall=1 -> LR and PC unchanged.
- Parametrised build: NUM_REGS=32, NUM_RD=3, PC_IDX=31, LR_IDX=30 -> write/read all 32 addresses. PC and LR behave as above at the new indices.
